// File: rtl/simon_state.sv
// rtl/simon_state.sv - Simon game main control FSM
module simon_state (
  input  logic CLK,
  input  logic RESET,
  input  logic START,
  input  logic rand_done,
  input  logic I_eq_J,
  input  logic J_max,
  input  logic timerout,
  input  logic count,
  input  logic yello,
  input  logic re,
  input  logic blu,
  input  logic gree,
  input  logic Yellow,
  input  logic Red,
  input  logic Blue,
  input  logic Green,
  output logic C_en,
  output logic I_en,
  output logic J_en,
  output logic I_cl,
  output logic J_cl,
  output logic g1,
  output logic g2,
  output logic g3,
  output logic g4
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    GEN      = 4'd1,
    SHOW_ON  = 4'd2,
    SHOW_OFF = 4'd3,
    WAIT_IN  = 4'd4,
    ECHO     = 4'd5,
    PAUSE    = 4'd6,
    WIN      = 4'd7,
    LOSE     = 4'd8
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_expect;
  logic [3:0] w_buttons;
  logic [3:0] w_lamps;

  assign w_expect  = {yello, re, blu, gree};
  assign w_buttons = {Yellow, Red, Blue, Green};
  assign {g1, g2, g3, g4} = w_lamps;

  // State register; reset wins over every other input, even mid-game
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, Moore lamp/timer decode and transition-qualified counter strobes
  always_comb begin
    w_next  = r_state;
    C_en    = 1'b0;
    I_en    = 1'b0;
    J_en    = 1'b0;
    I_cl    = 1'b0;
    J_cl    = 1'b0;
    w_lamps = 4'b0000;
    case (r_state)
      IDLE: begin
        I_cl = 1'b1;
        J_cl = 1'b1;
        if (START) w_next = GEN;
      end
      GEN: begin
        // Both indices held at zero so the first round is a single element
        I_cl = 1'b1;
        J_cl = 1'b1;
        if (rand_done) w_next = SHOW_ON;
      end
      SHOW_ON: begin
        C_en    = 1'b1;
        w_lamps = w_expect;
        if (timerout) w_next = SHOW_OFF;
      end
      SHOW_OFF: begin
        C_en = 1'b1;
        if (timerout) begin
          if (I_eq_J) begin
            I_cl   = 1'b1;
            w_next = WAIT_IN;
          end else begin
            I_en   = 1'b1;
            w_next = SHOW_ON;
          end
        end
      end
      WAIT_IN: begin
        C_en = 1'b1;
        // A press beats a simultaneous timeout; zero or several buttons never match one-hot E
        if (count) begin
          w_next = (w_buttons == w_expect) ? ECHO : LOSE;
        end else if (timerout) begin
          w_next = LOSE;
        end
      end
      ECHO: begin
        C_en    = 1'b1;
        w_lamps = w_expect;
        if (timerout) begin
          if (!I_eq_J) begin
            I_en   = 1'b1;
            w_next = WAIT_IN;
          end else if (J_max) begin
            w_next = WIN;
          end else begin
            J_en   = 1'b1;
            I_cl   = 1'b1;
            w_next = PAUSE;
          end
        end
      end
      PAUSE: begin
        C_en = 1'b1;
        if (timerout) w_next = SHOW_ON;
      end
      WIN: begin
        w_lamps = 4'b1111;
        if (START) w_next = GEN;
      end
      LOSE: begin
        w_lamps = 4'b1001;
        if (START) w_next = GEN;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_simon_state.sv
// tb/tb_simon_state.sv - scoreboard bench for simon_state
module tb_simon_state;

  logic CLK = 1'b0;
  logic RESET, START, rand_done, I_eq_J, J_max, timerout, count;
  logic yello, re, blu, gree, Yellow, Red, Blue, Green;
  logic C_en, I_en, J_en, I_cl, J_cl, g1, g2, g3, g4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [8:0] exp;
  } sb_t;
  sb_t sb_q[$];

  // Expected output vector: {C_en,I_en,J_en,I_cl,J_cl,g1,g2,g3,g4}
  localparam logic [8:0] O_IDLE = 9'b0_0_0_1_1_0000;
  localparam logic [8:0] O_TMR  = 9'b1_0_0_0_0_0000;
  localparam logic [8:0] O_ICL  = 9'b1_0_0_1_0_0000;
  localparam logic [8:0] O_IEN  = 9'b1_1_0_0_0_0000;
  localparam logic [8:0] O_LOSE = 9'b0_0_0_0_0_1001;
  localparam logic [8:0] O_WIN  = 9'b0_0_0_0_0_1111;

  simon_state dut (
    .CLK(CLK), .RESET(RESET), .START(START), .rand_done(rand_done),
    .I_eq_J(I_eq_J), .J_max(J_max), .timerout(timerout), .count(count),
    .yello(yello), .re(re), .blu(blu), .gree(gree),
    .Yellow(Yellow), .Red(Red), .Blue(Blue), .Green(Green),
    .C_en(C_en), .I_en(I_en), .J_en(J_en), .I_cl(I_cl), .J_cl(J_cl),
    .g1(g1), .g2(g2), .g3(g3), .g4(g4)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, queue expectation, compare settled outputs
  task automatic step(input string tag, input logic rst, input logic st, input logic rd,
                      input logic ieq, input logic jm, input logic to, input logic ct,
                      input logic [3:0] e, input logic [3:0] b, input logic [8:0] exp);
    sb_t item;
    @(negedge CLK);
    RESET = rst; START = st; rand_done = rd; I_eq_J = ieq; J_max = jm;
    timerout = to; count = ct;
    {yello, re, blu, gree} = e;
    {Yellow, Red, Blue, Green} = b;
    sb_q.push_back('{tag, exp});
    #2;
    item = sb_q.pop_front();
    check_eq(item.tag, {C_en, I_en, J_en, I_cl, J_cl, g1, g2, g3, g4}, item.exp);
  endtask

  initial begin
    @(negedge CLK);
    RESET = 0; START = 0; rand_done = 0; I_eq_J = 0; J_max = 0; timerout = 0; count = 0;
    {yello, re, blu, gree} = 4'b0000;
    {Yellow, Red, Blue, Green} = 4'b0000;

    //    tag            rst st rd ieq jm to ct  E        B        expected
    step("rst_hold",      0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, O_IDLE);
    step("idle",          1, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, O_IDLE);
    step("idle_start",    1, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, O_IDLE);
    step("gen_wait",      1, 0, 0, 0, 0, 0, 0, 4'b0100, 4'b0000, O_IDLE);
    step("gen_done",      1, 0, 1, 0, 0, 0, 0, 4'b0100, 4'b0000, O_IDLE);
    step("show_on",       1, 0, 0, 1, 0, 0, 0, 4'b0100, 4'b0000, 9'b1_0_0_0_0_0100);
    step("show_on_to",    1, 0, 0, 1, 0, 1, 0, 4'b0100, 4'b0000, 9'b1_0_0_0_0_0100);
    step("show_off",      1, 0, 0, 1, 0, 0, 0, 4'b0100, 4'b0000, O_TMR);
    step("show_off_icl",  1, 0, 0, 1, 0, 1, 0, 4'b0100, 4'b0000, O_ICL);
    step("wait_in",       1, 0, 0, 1, 0, 0, 0, 4'b0100, 4'b0000, O_TMR);
    step("wait_red_ok",   1, 0, 0, 1, 0, 0, 1, 4'b0100, 4'b0100, O_TMR);
    step("echo",          1, 0, 0, 1, 0, 0, 0, 4'b0100, 4'b0000, 9'b1_0_0_0_0_0100);
    step("echo_advance",  1, 0, 0, 1, 0, 1, 0, 4'b0100, 4'b0000, 9'b1_0_1_1_0_0100);
    step("pause",         1, 0, 0, 1, 0, 0, 1, 4'b0100, 4'b0100, O_TMR);
    step("pause_to",      1, 0, 0, 1, 0, 1, 0, 4'b0100, 4'b0000, O_TMR);
    step("show2_on_to",   1, 0, 0, 0, 0, 1, 0, 4'b0010, 4'b0000, 9'b1_0_0_0_0_0010);
    step("show2_off_ien", 1, 0, 0, 0, 0, 1, 0, 4'b0010, 4'b0000, O_IEN);
    step("show2b_on_to",  1, 0, 0, 1, 0, 1, 0, 4'b0100, 4'b0000, 9'b1_0_0_0_0_0100);
    step("show2b_off_to", 1, 0, 0, 1, 0, 1, 0, 4'b0100, 4'b0000, O_ICL);
    step("wait_blue_bad", 1, 0, 0, 1, 0, 0, 1, 4'b0100, 4'b0010, O_TMR);
    step("lose",          1, 0, 0, 1, 0, 1, 1, 4'b0100, 4'b0100, O_LOSE);
    step("lose_restart",  1, 1, 0, 1, 0, 0, 0, 4'b0100, 4'b0000, O_LOSE);
    step("gen2_done",     1, 0, 1, 1, 0, 0, 0, 4'b1000, 4'b0000, O_IDLE);
    step("show3_on_to",   1, 0, 0, 1, 0, 1, 0, 4'b1000, 4'b0000, 9'b1_0_0_0_0_1000);
    step("show3_off_to",  1, 0, 0, 1, 0, 1, 0, 4'b1000, 4'b0000, O_ICL);
    step("wait_timeout",  1, 0, 0, 1, 0, 1, 0, 4'b1000, 4'b0000, O_TMR);
    step("lose2_restart", 1, 1, 0, 1, 0, 0, 0, 4'b1000, 4'b0000, O_LOSE);
    step("gen3_done",     1, 0, 1, 1, 0, 0, 0, 4'b0001, 4'b0000, O_IDLE);
    step("show4_on_to",   1, 0, 0, 1, 0, 1, 0, 4'b0001, 4'b0000, 9'b1_0_0_0_0_0001);
    step("show4_off_to",  1, 0, 0, 1, 0, 1, 0, 4'b0001, 4'b0000, O_ICL);
    step("wait_cnt_to",   1, 0, 0, 1, 0, 1, 1, 4'b0001, 4'b0001, O_TMR);
    step("echo4",         1, 0, 0, 0, 0, 0, 0, 4'b0001, 4'b0000, 9'b1_0_0_0_0_0001);
    step("echo4_ien",     1, 0, 0, 0, 0, 1, 0, 4'b0001, 4'b0000, 9'b1_1_0_0_0_0001);
    step("wait_two_btn",  1, 0, 0, 1, 0, 0, 1, 4'b0001, 4'b0011, O_TMR);
    step("lose3_restart", 1, 1, 0, 1, 0, 0, 0, 4'b0001, 4'b0000, O_LOSE);
    step("gen4_done",     1, 0, 1, 1, 1, 0, 0, 4'b0100, 4'b0000, O_IDLE);
    step("show5_on_to",   1, 0, 0, 1, 1, 1, 0, 4'b0100, 4'b0000, 9'b1_0_0_0_0_0100);
    step("show5_off_to",  1, 0, 0, 1, 1, 1, 0, 4'b0100, 4'b0000, O_ICL);
    step("wait5_ok",      1, 0, 0, 1, 1, 0, 1, 4'b0100, 4'b0100, O_TMR);
    step("echo5_win",     1, 0, 0, 1, 1, 1, 0, 4'b0100, 4'b0000, 9'b1_0_0_0_0_0100);
    step("win",           1, 0, 0, 1, 1, 1, 1, 4'b0100, 4'b0100, O_WIN);
    step("win_restart",   1, 1, 0, 1, 1, 0, 0, 4'b0100, 4'b0000, O_WIN);
    step("gen5_wait",     1, 0, 0, 1, 0, 0, 0, 4'b0100, 4'b0000, O_IDLE);
    step("gen5_done",     1, 0, 1, 1, 0, 0, 0, 4'b0100, 4'b0000, O_IDLE);
    step("show6_rst",     0, 0, 0, 1, 0, 0, 0, 4'b0100, 4'b0000, 9'b1_0_0_0_0_0100);
    step("idle_after_rst",1, 0, 0, 1, 0, 0, 0, 4'b0100, 4'b0000, O_IDLE);
    step("rst_over_start",0, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, O_IDLE);
    step("idle_final",    1, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, O_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simon_state.md
Name: simon_state

Overview:
- Main control FSM for the Simon memory game.
- Sequences the random-colour playback, player input checking, round advance, and win/lose display.
- Drives the I (position) and J (round length) index counters, the shared interval-timer enable, and the four colour lamps.
- The sequence memory, random generator, timer, comparators and button conditioning are external.

Parameters:
none

Ports:
CLK  input  1  system clock, all state on rising edge
RESET  input  1  synchronous active-low reset
START  input  1  start/restart game request (level, sampled each clock)
rand_done  input  1  random sequence memory filled
I_eq_J  input  1  I == J (current position is last of round)
J_max  input  1  J at maximum sequence length
timerout  input  1  one-cycle pulse: timer interval elapsed (timer auto-restarts after pulse, cleared while C_en=0)
count  input  1  one-cycle strobe: valid player button press
yello  input  1  expected colour at index I, one-hot bit 3
re  input  1  expected colour, one-hot bit 2
blu  input  1  expected colour, one-hot bit 1
gree  input  1  expected colour, one-hot bit 0
Yellow  input  1  player button, valid when count=1
Red  input  1  player button
Blue  input  1  player button
Green  input  1  player button
C_en  output  1  timer enable
I_en  output  1  increment I (one-cycle pulse)
J_en  output  1  increment J (one-cycle pulse)
I_cl  output  1  clear I to 0
J_cl  output  1  clear J to 0
g1  output  1  yellow lamp
g2  output  1  red lamp
g3  output  1  blue lamp
g4  output  1  green lamp

Behaviour:
- Moore FSM, registered state. C_en and g1..g4 are decoded from state.
- I_en, J_en, I_cl and J_cl are decoded from state plus the transition condition; each is high only in the cycle the transition is taken, except where listed as state-level.
- RESET=0 at a clock edge forces IDLE, overriding any other input, including mid-game.
- Reset/IDLE outputs: I_cl=J_cl=1; all other outputs 0.
- Expected colour E = {yello,re,blu,gree}. Button vector B = {Yellow,Red,Blue,Green}.
- Lamps {g1,g2,g3,g4}: show E in SHOW_ON and ECHO; 1111 in WIN; 1001 in LOSE; 0000 elsewhere.
- States and transitions:
  - IDLE: I_cl=J_cl=1. START=1 -> GEN.
  - GEN: I_cl=J_cl=1. rand_done=1 -> SHOW_ON. First round is one element (I=J=0).
  - SHOW_ON: C_en=1. timerout -> SHOW_OFF.
  - SHOW_OFF: C_en=1.
    - timerout & !I_eq_J -> SHOW_ON, with I_en=1.
    - timerout & I_eq_J -> WAIT_IN, with I_cl=1.
  - WAIT_IN: C_en=1.
    - count & (B==E) -> ECHO.
    - count & (B!=E) -> LOSE. Multiple or zero buttons count as a mismatch.
    - timerout & !count -> LOSE. When count and timerout coincide, count has priority.
  - ECHO: C_en=1; lamps show E. On timerout:
    - !I_eq_J -> WAIT_IN, with I_en=1.
    - I_eq_J & J_max -> WIN.
    - I_eq_J & !J_max -> PAUSE, with J_en=1 and I_cl=1.
  - PAUSE: C_en=1, lamps off. timerout -> SHOW_ON.
  - WIN and LOSE: C_en=0. START=1 -> GEN, which clears I and J for a new game.
- Inputs not listed for a state are ignored: count outside WAIT_IN, START outside IDLE/WIN/LOSE, rand_done outside GEN.
- Never assert I_en and I_cl, or J_en and J_cl, in the same cycle.
- The timer restarts on each timerout, so back-to-back timed states need no C_en gap.

Test Plan:
- Reset: hold RESET=0 for 2 cycles, then release -> IDLE; I_cl=J_cl=1, C_en=0, g=0000. Assert RESET=0 mid-SHOW_ON -> IDLE next edge.
- Start and first playback: START pulse, rand_done=1, E=0100 (re=1), I_eq_J=1.
  - GEN -> SHOW_ON with g2=1, C_en=1.
  - timerout -> g=0000.
  - timerout -> WAIT_IN with a one-cycle I_cl pulse.
- Correct input and round advance: in WAIT_IN, count with Red=1 -> ECHO, g2=1. With I_eq_J=1 and J_max=0, timerout -> J_en=I_cl=1 for one cycle, then PAUSE, then SHOW_ON on the next timerout.
- Multi-element playback: I_eq_J=0 at SHOW_OFF timerout -> I_en pulse and return to SHOW_ON. Set I_eq_J=1 -> WAIT_IN.
- Wrong or late input:
  - count with Blue=1 while E=0100 -> LOSE, g=1001.
  - In a separate run, timerout in WAIT_IN without count -> LOSE.
  - count and timerout in the same cycle with a correct button -> ECHO.
- Win and restart: I_eq_J=1, J_max=1 at ECHO timerout -> WIN, g=1111, C_en=0. START -> GEN, I_cl=J_cl=1.
